// File: rtl/noc_link_pkg.sv
// rtl/noc_link_pkg.sv - shared flit type, packet FSM states and statistics helpers for the NoC credit link
package noc_link_pkg;

    localparam int STAT_WIDTH     = 32;
    localparam int DEF_FLIT_WIDTH = 64;
    localparam int DEF_DEST_WIDTH = 4;

    // Default flit layout; the link top re-derives the same layout from its own width parameters.
    typedef struct packed {
        logic [DEF_FLIT_WIDTH-1:0] data;
        logic [DEF_DEST_WIDTH-1:0] dest;
        logic                      is_tail;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/noc_link_stage.sv
// rtl/noc_link_stage.sv - one forward flit register plus one credit register for a single channel
module noc_link_stage
    import noc_link_pkg::*;
#(
    parameter type flit_t_p = flit_t
) (
    input  logic    clk_noc,
    input  logic    rst_noc_sync,
    input  flit_t_p flit_i,
    input  logic    send_i,
    input  logic    credit_i,
    output flit_t_p flit_o,
    output logic    send_o,
    output logic    credit_o
);

    flit_t_p flit_q;
    logic    send_q;
    logic    credit_q;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            send_q   <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            send_q   <= send_i;
            credit_q <= credit_i;
        end
    end

    // Payload is only meaningful alongside send, so it is neither reset nor loaded on idle cycles.
    always_ff @(posedge clk_noc) begin
        if (send_i) begin
            flit_q <= flit_i;
        end
    end

    assign flit_o   = flit_q;
    assign send_o   = send_q;
    assign credit_o = credit_q;

endmodule

// File: rtl/noc_credit_link.sv
// rtl/noc_credit_link.sv - pipelined credit-based NoC link with per-channel checking; NOC_LINK_STATS_EN adds flit/packet counters
module noc_credit_link
    import noc_link_pkg::*;
#(
    parameter int NUM_CHANNELS      = 4,
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 4,
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_BUFFER_DEPTH = 1,
    localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_noc_sync,
    input  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0]  data_in,
    input  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0]  dest_in,
    input  logic [NUM_CHANNELS-1:0]                  is_tail_in,
    input  logic [NUM_CHANNELS-1:0]                  send_in,
    output logic [NUM_CHANNELS-1:0]                  credit_out,
    output logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0]  data_out,
    output logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0]  dest_out,
    output logic [NUM_CHANNELS-1:0]                  is_tail_out,
    output logic [NUM_CHANNELS-1:0]                  send_out,
    input  logic [NUM_CHANNELS-1:0]                  credit_in,
    output logic [NUM_CHANNELS-1:0][CW-1:0]          credit_level,
    output logic [NUM_CHANNELS-1:0]                  err_credit,
    output logic [NUM_CHANNELS-1:0]                  err_pkt,
    output logic [NUM_CHANNELS-1:0][STAT_WIDTH-1:0]  flit_count,
    output logic [NUM_CHANNELS-1:0][STAT_WIDTH-1:0]  pkt_count
);

    localparam logic [CW-1:0] DEPTH_L = CW'(FLIT_BUFFER_DEPTH);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } chan_flit_t;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        chan_flit_t              flit_pipe [NUM_PIPELINE+1];
        logic [NUM_PIPELINE:0]   send_pipe;
        logic [NUM_PIPELINE:0]   crd_pipe;

        assign flit_pipe[0] = {data_in[ch], dest_in[ch], is_tail_in[ch]};
        assign send_pipe[0] = send_in[ch];
        assign crd_pipe[0]  = credit_in[ch];

        for (genvar st = 0; st < NUM_PIPELINE; st++) begin : g_stage
            noc_link_stage #(
                .flit_t_p (chan_flit_t)
            ) u_stage (
                .clk_noc      (clk_noc),
                .rst_noc_sync (rst_noc_sync),
                .flit_i       (flit_pipe[st]),
                .send_i       (send_pipe[st]),
                .credit_i     (crd_pipe[st]),
                .flit_o       (flit_pipe[st+1]),
                .send_o       (send_pipe[st+1]),
                .credit_o     (crd_pipe[st+1])
            );
        end

        assign data_out[ch]    = flit_pipe[NUM_PIPELINE].data;
        assign dest_out[ch]    = flit_pipe[NUM_PIPELINE].dest;
        assign is_tail_out[ch] = flit_pipe[NUM_PIPELINE].is_tail;
        assign send_out[ch]    = send_pipe[NUM_PIPELINE];
        assign credit_out[ch]  = crd_pipe[NUM_PIPELINE];

        logic            snd;
        logic            crd;
        logic [CW-1:0]   level_q;
        logic [CW-1:0]   level_d;
        logic            err_credit_q;
        logic            crd_viol;

        assign snd = send_in[ch];
        assign crd = crd_pipe[NUM_PIPELINE];

        // Violations hold the counter; a credit matched by a send never overflows.
        always_comb begin
            level_d  = level_q;
            crd_viol = 1'b0;
            if (snd && (level_q == '0)) begin
                crd_viol = 1'b1;
            end else if (snd && !crd) begin
                level_d = level_q - CW'(1);
            end else if (crd && !snd) begin
                if (level_q == DEPTH_L) begin
                    crd_viol = 1'b1;
                end else begin
                    level_d = level_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk_noc) begin
            if (rst_noc_sync) begin
                level_q      <= DEPTH_L;
                err_credit_q <= 1'b0;
            end else begin
                level_q      <= level_d;
                err_credit_q <= err_credit_q | crd_viol;
            end
        end

        pkt_state_e              state_q;
        logic [DEST_WIDTH-1:0]   head_dest_q;
        logic                    err_pkt_q;

        always_ff @(posedge clk_noc) begin
            if (rst_noc_sync) begin
                state_q     <= IDLE;
                head_dest_q <= '0;
                err_pkt_q   <= 1'b0;
            end else if (snd) begin
                case (state_q)
                    IDLE: begin
                        if (!is_tail_in[ch]) begin
                            state_q     <= IN_PKT;
                            head_dest_q <= dest_in[ch];
                        end
                    end
                    IN_PKT: begin
                        if (dest_in[ch] != head_dest_q) begin
                            err_pkt_q <= 1'b1;
                        end
                        if (is_tail_in[ch]) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign credit_level[ch] = level_q;
        assign err_credit[ch]   = err_credit_q;
        assign err_pkt[ch]      = err_pkt_q;

`ifdef NOC_LINK_STATS_EN
        logic [STAT_WIDTH-1:0] flit_cnt_q;
        logic [STAT_WIDTH-1:0] pkt_cnt_q;

        always_ff @(posedge clk_noc) begin
            if (rst_noc_sync) begin
                flit_cnt_q <= '0;
                pkt_cnt_q  <= '0;
            end else if (snd) begin
                flit_cnt_q <= sat_inc(flit_cnt_q);
                if (is_tail_in[ch]) begin
                    pkt_cnt_q <= sat_inc(pkt_cnt_q);
                end
            end
        end

        assign flit_count[ch] = flit_cnt_q;
        assign pkt_count[ch]  = pkt_cnt_q;
`else
        assign flit_count[ch] = '0;
        assign pkt_count[ch]  = '0;
`endif
    end

endmodule
